// File: rtl/ayatsuki_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ayatsuki_mem_arbiter
// Description : Two-requester (fetch I / data D) arbiter for a single-port
//               memory. It grants one access every two cycles. D has priority
//               unless I has been starved for STARVE_LIMIT consecutive D
//               grants. Misaligned or out-of-range accesses are rejected
//               without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
module ayatsuki_mem_arbiter #(
  parameter int ADDR_MAX     = 2044,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  // single-port memory
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int                 c_cnt_w      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_starve_lim = c_cnt_w'(STARVE_LIMIT);
  localparam logic [31:0]        c_addr_max   = 32'(ADDR_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_starve_cnt;
  logic               r_i_done;
  logic               r_i_err;
  logic               r_d_done;
  logic               r_d_err;

  logic w_idle;
  logic w_i_bad;
  logic w_d_bad;
  logic w_starved;
  logic w_grant_d;
  logic w_grant_i;
  logic w_ok_d;
  logic w_ok_i;

  // Legality of each request address: word aligned and within range.
  assign w_i_bad = (i_addr[1:0] != 2'b00) || (i_addr > c_addr_max);
  assign w_d_bad = (d_addr[1:0] != 2'b00) || (d_addr > c_addr_max);

  // Grants are only issued from IDLE; D wins unless I has hit the starvation limit.
  assign w_idle    = (r_state == IDLE);
  assign w_starved = i_req && (r_starve_cnt == c_starve_lim);
  assign w_grant_d = w_idle && d_req && !w_starved;
  assign w_grant_i = w_idle && i_req && !w_grant_d;

  // A rejected grant still consumes the slot but never reaches the memory.
  assign w_ok_d = w_grant_d && !w_d_bad;
  assign w_ok_i = w_grant_i && !w_i_bad;

  // Memory access is presented combinationally in the grant cycle; reset
  // blocks any access so nothing is committed while rst_n is low.
  assign mem_en    = rst_n & (w_ok_d | w_ok_i);
  assign mem_we    = rst_n & w_ok_d & d_we;
  assign mem_addr  = w_grant_d ? d_addr : i_addr;
  assign mem_wdata = d_wdata;

  // Read data arrives one cycle after the grant, i.e. in the done cycle.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Completion flags are suppressed while reset is held so an aborted
  // transaction never shows a done pulse.
  assign i_done = rst_n & r_i_done;
  assign i_err  = rst_n & r_i_err;
  assign d_done = rst_n & r_d_done;
  assign d_err  = rst_n & r_d_err;

  // Arbitration FSM with registered completion flags and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_i_done     <= 1'b0;
      r_i_err      <= 1'b0;
      r_d_done     <= 1'b0;
      r_d_err      <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_i_err  <= 1'b0;
      r_d_done <= 1'b0;
      r_d_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state  <= BUSY_D;
            r_d_done <= 1'b1;
            r_d_err  <= w_d_bad;
            if (i_req) begin
              if (r_starve_cnt != c_starve_lim) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end else begin
              r_starve_cnt <= '0;
            end
          end else if (w_grant_i) begin
            r_state      <= BUSY_I;
            r_i_done     <= 1'b1;
            r_i_err      <= w_i_bad;
            r_starve_cnt <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ayatsuki_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ayatsuki_mem_arbiter
// Description : Self-checking bench for ayatsuki_mem_arbiter: a directed
//               vector table plus hand-written contention, idle and
//               reset-abort sequences against a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ayatsuki_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        tb_clear;
  logic [31:0] mem [512];

  int errors = 0;
  int checks = 0;

  ayatsuki_mem_arbiter #(
    .ADDR_MAX     (2044),
    .STARVE_LIMIT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory: write commits on the edge, read data one cycle later.
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int k = 0; k < 512; k++) mem[k] <= 32'hA000_0000 | 32'(k);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[10:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[10:2]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_idone;
    logic        e_ierr;
    logic        e_ddone;
    logic        e_derr;
    logic        e_chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dwd,
                              logic en, logic we, logic [31:0] ea,
                              logic idn, logic ier, logic ddn, logic der,
                              logic crd, logic [31:0] erd);
    vec_t v;
    v.i_req = ir;  v.i_addr = ia;  v.d_req = dr;  v.d_we = dw;
    v.d_addr = da; v.d_wdata = dwd;
    v.e_en = en;   v.e_we = we;    v.e_addr = ea;
    v.e_idone = idn; v.e_ierr = ier; v.e_ddone = ddn; v.e_derr = der;
    v.e_chk_rd = crd; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tb_clear = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    //          ireq iaddr        dreq we daddr        dwdata         en we addr      id ie dd de crd rdata
    vecs[0]  = mk(0, 32'h0,       0, 0, 32'h0,       32'h0,         0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 32'h8,       0, 0, 32'h0,       32'h0,         1, 0, 32'h8,    0, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 32'h8,       0, 0, 32'h0,       32'h0,         0, 0, 32'h0,    1, 0, 0, 0, 1, 32'hA000_0002);
    vecs[3]  = mk(0, 32'h0,       1, 1, 32'h10,      32'hDEAD_BEEF, 1, 1, 32'h10,   0, 0, 0, 0, 0, 32'h0);
    vecs[4]  = mk(0, 32'h0,       0, 1, 32'h10,      32'hDEAD_BEEF, 0, 0, 32'h0,    0, 0, 1, 0, 0, 32'h0);
    vecs[5]  = mk(0, 32'h0,       1, 0, 32'h10,      32'h0,         1, 0, 32'h10,   0, 0, 0, 0, 0, 32'h0);
    vecs[6]  = mk(0, 32'h0,       0, 0, 32'h10,      32'h0,         0, 0, 32'h0,    0, 0, 1, 0, 1, 32'hDEAD_BEEF);
    vecs[7]  = mk(0, 32'h0,       1, 1, 32'h12,      32'h1234_5678, 0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0);
    vecs[8]  = mk(0, 32'h0,       0, 1, 32'h12,      32'h1234_5678, 0, 0, 32'h0,    0, 0, 1, 1, 0, 32'h0);
    vecs[9]  = mk(0, 32'h0,       1, 0, 32'h10,      32'h0,         1, 0, 32'h10,   0, 0, 0, 0, 0, 32'h0);
    vecs[10] = mk(0, 32'h0,       0, 0, 32'h10,      32'h0,         0, 0, 32'h0,    0, 0, 1, 0, 1, 32'hDEAD_BEEF);
    vecs[11] = mk(1, 32'd2048,    0, 0, 32'h0,       32'h0,         0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0);
    vecs[12] = mk(0, 32'd2048,    0, 0, 32'h0,       32'h0,         0, 0, 32'h0,    1, 1, 0, 0, 0, 32'h0);
    vecs[13] = mk(1, 32'd2044,    0, 0, 32'h0,       32'h0,         1, 0, 32'd2044, 0, 0, 0, 0, 0, 32'h0);
    vecs[14] = mk(0, 32'd2044,    0, 0, 32'h0,       32'h0,         0, 0, 32'h0,    1, 0, 0, 0, 1, 32'hA000_01FF);
    vecs[15] = mk(0, 32'h0,       1, 0, 32'd2048,    32'h0,         0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0);
    vecs[16] = mk(0, 32'h0,       0, 0, 32'd2048,    32'h0,         0, 0, 32'h0,    0, 0, 1, 1, 0, 32'h0);

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset mem_en", 32'(mem_en), 32'h0);
    chk("reset mem_we", 32'(mem_we), 32'h0);
    chk("reset i_done", 32'(i_done), 32'h0);
    chk("reset d_done", 32'(d_done), 32'h0);
    chk("reset starve_cnt", 32'(dut.r_starve_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; tb_clear = 1'b0;

    // Directed vector table, one cycle per record
    for (int k = 0; k < 17; k++) begin
      i_req = vecs[k].i_req; i_addr = vecs[k].i_addr;
      d_req = vecs[k].d_req; d_we = vecs[k].d_we;
      d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
      @(negedge clk);
      chk($sformatf("v%0d mem_en", k), 32'(mem_en), 32'(vecs[k].e_en));
      chk($sformatf("v%0d mem_we", k), 32'(mem_we), 32'(vecs[k].e_we));
      if (vecs[k].e_en) chk($sformatf("v%0d mem_addr", k), mem_addr, vecs[k].e_addr);
      chk($sformatf("v%0d i_done", k), 32'(i_done), 32'(vecs[k].e_idone));
      chk($sformatf("v%0d i_err", k),  32'(i_err),  32'(vecs[k].e_ierr));
      chk($sformatf("v%0d d_done", k), 32'(d_done), 32'(vecs[k].e_ddone));
      chk($sformatf("v%0d d_err", k),  32'(d_err),  32'(vecs[k].e_derr));
      if (vecs[k].e_chk_rd) begin
        if (vecs[k].e_idone) chk($sformatf("v%0d i_rdata", k), i_rdata, vecs[k].e_rdata);
        else                 chk($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].e_rdata);
      end
      next_cycle();
    end
    drop_reqs();
    chk("starve_cnt after singles", 32'(dut.r_starve_cnt), 32'h0);

    // Contention: both requests held high, expected order D,D,D,I repeated
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int g = 0; g < 8; g++) begin
      logic exp_i;
      exp_i = ((g % 4) == 3);
      @(negedge clk);
      chk($sformatf("cont%0d grant mem_en", g), 32'(mem_en), 32'h1);
      chk($sformatf("cont%0d grant addr", g), mem_addr, exp_i ? 32'h8 : 32'h20);
      chk($sformatf("cont%0d done in grant", g), 32'(i_done | d_done), 32'h0);
      next_cycle();
      if (g == 7) drop_reqs();
      @(negedge clk);
      chk($sformatf("cont%0d busy mem_en", g), 32'(mem_en), 32'h0);
      chk($sformatf("cont%0d i_done", g), 32'(i_done), 32'(exp_i));
      chk($sformatf("cont%0d d_done", g), 32'(d_done), 32'(!exp_i));
      next_cycle();
    end
    chk("starve_cnt after I grant", 32'(dut.r_starve_cnt), 32'h0);

    // Two starving D grants leave the counter at 2
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      chk($sformatf("pre-idle%0d addr", g), mem_addr, 32'h20);
      next_cycle();
      if (g == 1) drop_reqs();
      next_cycle();
    end
    chk("starve_cnt before idle", 32'(dut.r_starve_cnt), 32'h2);

    // Idle bus for 10 cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d mem_en", c), 32'(mem_en), 32'h0);
      chk($sformatf("idle%0d done", c), 32'({i_done, d_done}), 32'h0);
      next_cycle();
    end
    chk("starve_cnt after idle", 32'(dut.r_starve_cnt), 32'h2);

    // Reset during BUSY_D: store commits, no done pulse, counter cleared
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rst-op grant mem_we", 32'(mem_we), 32'h1);
    chk("rst-op grant addr", mem_addr, 32'h40);
    next_cycle();
    chk("rst-op starve_cnt in busy", 32'(dut.r_starve_cnt), 32'h3);
    rst_n = 1'b0;
    drop_reqs();
    @(negedge clk);
    chk("rst-op d_done suppressed", 32'(d_done), 32'h0);
    chk("rst-op i_done suppressed", 32'(i_done), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst outputs", 32'({mem_en, mem_we, i_done, d_done, i_err, d_err}), 32'h0);
    chk("post-rst starve_cnt", 32'(dut.r_starve_cnt), 32'h0);
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(negedge clk);
    chk("post-rst load mem_en", 32'(mem_en), 32'h1);
    next_cycle();
    drop_reqs();
    @(negedge clk);
    chk("post-rst load d_done", 32'(d_done), 32'h1);
    chk("post-rst load d_rdata", d_rdata, 32'hCAFE_F00D);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
